// File: rtl/ldo_thermo_controller.sv
// ldo_thermo_controller: adaptive-step thermometer loop driving active-low pass-cell gates (ports: clock, rst, en, cmp_up/cmp_dn in; vg, code, sat_hi, sat_lo, locked, cmp_err out)
module ldo_thermo_controller #(
  parameter int N_CELLS        = 32,
  parameter int CNT_W          = 6,
  parameter int BOOST_RUN      = 4,
  parameter int MAX_STEP       = 8,
  parameter int LOCK_REVERSALS = 4
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               en,
  input  logic               cmp_up,
  input  logic               cmp_dn,
  output logic [N_CELLS-1:0] vg,
  output logic [CNT_W-1:0]   code,
  output logic               sat_hi,
  output logic               sat_lo,
  output logic               locked,
  output logic               cmp_err
);
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;
  localparam logic [CNT_W:0]   NC  = (CNT_W+1)'(N_CELLS);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] BR  = CNT_W'(BOOST_RUN);
  localparam logic [CNT_W-1:0] MS  = CNT_W'(MAX_STEP);
  localparam logic [CNT_W-1:0] LR  = CNT_W'(LOCK_REVERSALS);
  logic               r_up_q, r_dn_q;
  logic [CNT_W-1:0]   r_code, r_step, r_run, r_rev;
  dir_t               r_dir;
  logic               r_locked, r_err, r_sat_hi, r_sat_lo;
  logic [N_CELLS-1:0] r_vg;
  logic               w_up, w_dn, w_inv, w_same, w_sat_req;
  dir_t               w_dir_req, w_dir_nx;
  logic [CNT_W-1:0]   w_amt, w_run_inc, w_step_dbl, w_step_boost;
  logic [CNT_W:0]     w_sum, w_up_c, w_dn_c;
  logic [CNT_W-1:0]   w_clamped, w_code_nx, w_step_nx, w_run_nx, w_rev_nx;
  logic               w_locked_nx, w_err_nx;
  logic [N_CELLS-1:0] w_vg_nx;
  assign w_up      = r_up_q & ~r_dn_q;
  assign w_dn      = ~r_up_q & r_dn_q;
  assign w_inv     = ~(w_up | w_dn);
  assign w_dir_req = w_up ? DIR_UP : DIR_DN;
  assign w_same    = (r_dir == DIR_NONE) || (r_dir == w_dir_req);
  assign w_sat_req = (w_up && {1'b0, r_code} == NC) || (w_dn && r_code == '0);
  // a reversal always moves by one cell regardless of the accumulated step
  assign w_amt     = w_same ? r_step : ONE;
  // one extra bit of headroom so an overshoot clamps instead of wrapping
  assign w_sum     = {1'b0, r_code} + {1'b0, w_amt};
  assign w_up_c    = (w_sum > NC) ? NC : w_sum;
  assign w_dn_c    = (w_amt > r_code) ? '0 : {1'b0, r_code} - {1'b0, w_amt};
  assign w_clamped = w_up ? CNT_W'(w_up_c) : CNT_W'(w_dn_c);
  assign w_run_inc    = r_run + ONE;
  assign w_step_dbl   = {r_step[CNT_W-2:0], 1'b0};
  assign w_step_boost = (w_step_dbl > MS) ? MS : w_step_dbl;
  always_comb begin
    w_code_nx   = r_code;
    w_step_nx   = r_step;
    w_run_nx    = r_run;
    w_rev_nx    = r_rev;
    w_dir_nx    = r_dir;
    w_locked_nx = r_locked;
    w_err_nx    = 1'b0;
    if (!en) begin
      w_code_nx   = '0;
      w_step_nx   = ONE;
      w_run_nx    = '0;
      w_rev_nx    = '0;
      w_dir_nx    = DIR_NONE;
      w_locked_nx = 1'b0;
    end else if (w_inv) begin
      w_step_nx = ONE;
      w_run_nx  = '0;
      w_err_nx  = 1'b1;
    end else if (w_sat_req) begin
      w_dir_nx = w_dir_req;
    end else if (w_same) begin
      w_code_nx   = w_clamped;
      w_run_nx    = (w_run_inc == BR) ? '0 : w_run_inc;
      w_step_nx   = (w_run_inc == BR) ? w_step_boost : r_step;
      w_rev_nx    = '0;
      w_dir_nx    = w_dir_req;
      w_locked_nx = (r_dir == DIR_NONE) ? r_locked : 1'b0;
    end else begin
      w_code_nx   = w_clamped;
      w_step_nx   = ONE;
      w_run_nx    = ONE;
      w_dir_nx    = w_dir_req;
      // only back-to-back unit-step reversals build up toward lock
      w_rev_nx    = (r_step != ONE) ? ONE : (r_rev == LR) ? LR : r_rev + ONE;
      w_locked_nx = (w_rev_nx == LR);
    end
  end
  for (genvar i = 0; i < N_CELLS; i++) begin : g_vg
    assign w_vg_nx[i] = ~({1'b0, w_code_nx} > (CNT_W+1)'(i));
  end
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_up_q <= 1'b0;
      r_dn_q <= 1'b0;
    end else begin
      r_up_q <= cmp_up;
      r_dn_q <= cmp_dn;
    end
  end
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_code   <= '0;
      r_step   <= ONE;
      r_run    <= '0;
      r_rev    <= '0;
      r_dir    <= DIR_NONE;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_sat_hi <= 1'b0;
      r_sat_lo <= 1'b1;
      r_vg     <= '1;
    end else begin
      r_code   <= w_code_nx;
      r_step   <= w_step_nx;
      r_run    <= w_run_nx;
      r_rev    <= w_rev_nx;
      r_dir    <= w_dir_nx;
      r_locked <= w_locked_nx;
      r_err    <= w_err_nx;
      r_sat_hi <= ({1'b0, w_code_nx} == NC);
      r_sat_lo <= (w_code_nx == '0);
      r_vg     <= w_vg_nx;
    end
  end
  assign vg      = r_vg;
  assign code    = r_code;
  assign sat_hi  = r_sat_hi;
  assign sat_lo  = r_sat_lo;
  assign locked  = r_locked;
  assign cmp_err = r_err;
endmodule

// File: tb/tb_ldo_thermo_controller.sv
// tb_ldo_thermo_controller: directed-vector self-checking bench for ldo_thermo_controller
module tb_ldo_thermo_controller;
  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        cmp_up = 1'b0;
  logic        cmp_dn = 1'b0;
  logic [31:0] vg;
  logic [5:0]  code;
  logic        sat_hi, sat_lo, locked, cmp_err;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  ldo_thermo_controller dut (
    .clock(clock), .rst(rst), .en(en), .cmp_up(cmp_up), .cmp_dn(cmp_dn),
    .vg(vg), .code(code), .sat_hi(sat_hi), .sat_lo(sat_lo),
    .locked(locked), .cmp_err(cmp_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic u, input logic d);
    cmp_up = u;
    cmp_dn = d;
    @(posedge clock);
    #1;
  endtask
  function automatic logic [31:0] therm(input int c);
    logic [31:0] v;
    v = '1;
    for (int i = 0; i < c; i++) v[i] = 1'b0;
    return v;
  endfunction
  int ramp [13] = '{1, 2, 3, 4, 6, 8, 10, 12, 16, 20, 24, 28, 32};
  int tab [20][4] = '{
    '{1,0, 1,0}, '{1,0, 2,0}, '{1,0, 3,0}, '{1,0, 4,0}, '{1,0, 6,0},
    '{1,0, 8,0}, '{1,0,10,0}, '{1,0,12,0}, '{0,1,16,0}, '{0,1,15,0},
    '{1,0,14,0}, '{0,1,15,0}, '{1,0,14,0}, '{0,1,15,0}, '{1,0,14,1},
    '{1,0,15,1}, '{1,0,16,0}, '{1,0,17,0}, '{1,0,18,0}, '{1,0,20,0}
  };
  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_code", 32'(code), 0);
    chk("rst_vg", vg, 32'hFFFF_FFFF);
    chk("rst_sat_lo", 32'(sat_lo), 1);
    chk("rst_sat_hi", 32'(sat_hi), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(cmp_err), 0);
    rst = 1'b0;
    en = 1'b1;
    cyc(1, 0);
    chk("first_invalid_err", 32'(cmp_err), 1);
    chk("first_invalid_code", 32'(code), 0);
    for (int i = 0; i < 13; i++) begin
      cyc(1, 0);
      chk($sformatf("ramp%0d", i), 32'(code), 32'(ramp[i]));
      chk($sformatf("ramp_vg%0d", i), vg, therm(ramp[i]));
    end
    chk("top_sat_hi", 32'(sat_hi), 1);
    chk("top_vg", vg, 0);
    repeat (2) cyc(1, 0);
    chk("top_hold", 32'(code), 32);
    chk("top_hold_err", 32'(cmp_err), 0);
    en = 1'b0;
    cyc(1, 0);
    chk("en_off_code", 32'(code), 0);
    chk("en_off_vg", vg, 32'hFFFF_FFFF);
    chk("en_off_sat_lo", 32'(sat_lo), 1);
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 0);
      chk($sformatf("en_ramp%0d", i), 32'(code), 32'(i));
    end
    cyc(1, 1);
    chk("pre_inv_code", 32'(code), 6);
    cyc(1, 0);
    chk("inv_code", 32'(code), 6);
    chk("inv_err", 32'(cmp_err), 1);
    cyc(1, 0);
    chk("post_inv_code", 32'(code), 7);
    chk("post_inv_err", 32'(cmp_err), 0);
    en = 1'b0;
    cyc(1, 0);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(tab[i][0][0], tab[i][1][0]);
      chk($sformatf("seq_code%0d", i), 32'(code), 32'(tab[i][2]));
      chk($sformatf("seq_locked%0d", i), 32'(locked), 32'(tab[i][3]));
    end
    rst = 1'b1;
    #1;
    chk("async_code", 32'(code), 0);
    chk("async_vg", vg, 32'hFFFF_FFFF);
    chk("async_sat_lo", 32'(sat_lo), 1);
    chk("async_locked", 32'(locked), 0);
    @(posedge clock);
    #1;
    rst = 1'b0;
    cyc(0, 1);
    cyc(0, 1);
    chk("dn_at_zero_code", 32'(code), 0);
    chk("dn_at_zero_err", 32'(cmp_err), 0);
    chk("dn_at_zero_sat_lo", 32'(sat_lo), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
